// File: rtl/bus_read_arbiter.sv
// Round-robin read arbiter driving a registered word onto the shared bus.
// Ports: clk, clr (sync high), rd_req/src_data in; bus_ready; bus_* out, pending, busy, overflow.
module bus_read_arbiter #(
   parameter int NUM_SRC = 24,
   parameter int WIDTH   = 32,
   parameter int SRC_W   = 5
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic [NUM_SRC-1:0]       rd_req,
   input  logic [NUM_SRC*WIDTH-1:0] src_data,
   input  logic                     bus_ready,
   output logic [WIDTH-1:0]         bus_data,
   output logic [SRC_W-1:0]         bus_src,
   output logic                     bus_valid,
   output logic [NUM_SRC-1:0]       pending,
   output logic                     busy,
   output logic                     overflow
);

   typedef enum logic {
      ST_IDLE,
      ST_SERVE
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WIDTH-1:0]     r_bus_data;
   logic [SRC_W-1:0]     r_bus_src;
   logic [NUM_SRC-1:0]   r_pending;
   logic                 r_overflow;
   logic [SRC_W-1:0]     r_rr_ptr;

   logic [NUM_SRC-1:0]   w_elig;
   logic                 w_can_load;
   logic                 w_found;
   logic                 w_grant;
   logic [SRC_W-1:0]     w_idx;
   logic [NUM_SRC-1:0]   w_gnt_oh;
   logic [WIDTH-1:0]     w_data;
   logic [SRC_W-1:0]     w_ptr_nxt;

   assign bus_valid = (r_state == ST_SERVE);
   assign bus_data  = r_bus_data;
   assign bus_src   = r_bus_src;
   assign pending   = r_pending;
   assign overflow  = r_overflow;
   assign busy      = bus_valid | (|r_pending);

   // Priority scan starting at rr_ptr, wrapping past the last source.
   always_comb begin
      int s;
      w_elig     = r_pending | rd_req;
      w_can_load = !bus_valid | bus_ready;
      w_found    = 1'b0;
      w_idx      = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         s = int'(r_rr_ptr) + k;
         if (s >= NUM_SRC) s = s - NUM_SRC;
         if (!w_found && w_elig[s]) begin
            w_found = 1'b1;
            w_idx   = SRC_W'(s);
         end
      end
      w_grant   = w_can_load & w_found;
      w_gnt_oh  = w_grant ? (NUM_SRC'(1) << w_idx) : '0;
      w_data    = src_data[int'(w_idx)*WIDTH +: WIDTH];
      w_ptr_nxt = (int'(w_idx) == NUM_SRC-1) ? '0 : w_idx + 1'b1;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_found) w_state_nxt = ST_SERVE;
         ST_SERVE: if (bus_ready && !w_found) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state    <= ST_IDLE;
         r_bus_data <= '0;
         r_bus_src  <= '0;
         r_pending  <= '0;
         r_overflow <= 1'b0;
         r_rr_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_bus_data <= w_data;
            r_bus_src  <= w_idx;
            r_rr_ptr   <= w_ptr_nxt;
         end
         r_pending  <= w_elig & ~w_gnt_oh;
         // Held-word source is not in pending, so a repeat of it queues cleanly.
         r_overflow <= |(rd_req & r_pending);
      end
   end

endmodule
